jtframe_dump_ctrl: RTL and testbench

Frame-windowed waveform-capture controller for game simulations and on-chip debug capture. Counts frames from falling edges of the vertical sync and drives CH independent capture-enable channels. Each channel is opened and closed at programmed frame numbers or relative to the end of a ROM download. It sits beside the game core in the test harness and frame, and replaces fixed single-start dump triggers with parametrised multi-window control.

---
 rtl/jtframe_dump_pkg.sv | 49 ++++
 rtl/jtframe_dump_win.sv | 134 +++++++++++++
 rtl/jtframe_dump_ctrl.sv | 88 ++++++++
 tb/tb_jtframe_dump_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_dump_pkg.sv
// Shared types and helpers for the frame-windowed dump controller.
// Optional feature macro: JTFRAME_DUMP_LOADROM_EN (enables LOAD mode).
package jtframe_dump_pkg;

    // Widest frame counter the helpers below can handle
    localparam int FW_MAX = 64;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ONESHOT = 2'd1,
        MODE_LOAD    = 2'd2,
        MODE_FREE    = 2'd3
    } dump_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } ch_state_e;

    // All-ones value of a w-bit counter, zero-extended to FW_MAX bits
    function automatic logic [FW_MAX-1:0] cnt_max(input int unsigned w);
        logic [FW_MAX-1:0] m;
        if (w >= 32'd64) begin
            m = {FW_MAX{1'b1}};
        end else begin
            m = (64'd1 << w) - 64'd1;
        end
        return m;
    endfunction

    // True when a w-bit counter has reached its ceiling
    function automatic logic cnt_sat(input logic [FW_MAX-1:0] v, input int unsigned w);
        return (v == cnt_max(w));
    endfunction

    // Increment that sticks at the ceiling instead of wrapping
    function automatic logic [FW_MAX-1:0] sat_inc(input logic [FW_MAX-1:0] v, input int unsigned w);
        logic [FW_MAX-1:0] r;
        if (cnt_sat(v, w)) begin
            r = v;
        end else begin
            r = v + 64'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/jtframe_dump_win.sv
// One capture channel: latches its mode/start/stop when armed and walks
// IDLE -> WAIT -> ACTIVE -> DONE against the shared frame counter.
// Optional feature macro: JTFRAME_DUMP_LOADROM_EN (LOAD mode, dl_fall input).
module jtframe_dump_win
    import jtframe_dump_pkg::*;
#(
    parameter int FW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init,
    input  logic          rearm,
    input  logic          tick,
    input  logic [FW-1:0] nxt,
`ifdef JTFRAME_DUMP_LOADROM_EN
    input  logic          dl_fall,
`endif
    input  logic [1:0]    mode,
    input  logic [FW-1:0] start,
    input  logic [FW-1:0] stop,
    output logic          dump_en,
    output logic          dump_en_nxt,
    output logic          done
);

    dump_mode_e    mode_eff_s;
    dump_mode_e    mode_r;
    dump_mode_e    mode_nxt_s;
    ch_state_e     state_r;
    ch_state_e     state_nxt_s;
    logic [FW-1:0] start_r;
    logic [FW-1:0] stop_r;
    logic [FW-1:0] start_nxt_s;
    logic [FW-1:0] stop_nxt_s;

    // Map the requested mode to the one this build supports
    always_comb begin
        mode_eff_s = dump_mode_e'(mode);
`ifndef JTFRAME_DUMP_LOADROM_EN
        if (mode == MODE_LOAD) begin
            mode_eff_s = MODE_OFF;
        end else begin
            mode_eff_s = dump_mode_e'(mode);
        end
`endif
    end

    // Next-state logic; arming (startup or rearm) outranks any frame match
    always_comb begin
        state_nxt_s = state_r;
        mode_nxt_s  = mode_r;
        start_nxt_s = start_r;
        stop_nxt_s  = stop_r;
        if (rearm || (init && (state_r == ST_IDLE))) begin
            mode_nxt_s  = mode_eff_s;
            start_nxt_s = start;
            stop_nxt_s  = stop;
            if (mode_eff_s == MODE_OFF) begin
                state_nxt_s = ST_IDLE;
            end else begin
                state_nxt_s = ST_WAIT;
            end
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_IDLE;
                ST_WAIT: begin
                    case (mode_r)
                        MODE_ONESHOT, MODE_FREE: begin
                            if (start_r == '0) begin
                                state_nxt_s = ST_ACTIVE;
                            end else if (tick && (nxt == start_r)) begin
                                // A stop at or before start closes the window unopened
                                if ((mode_r == MODE_ONESHOT) && (stop_r != '0) && (stop_r <= start_r)) begin
                                    state_nxt_s = ST_DONE;
                                end else begin
                                    state_nxt_s = ST_ACTIVE;
                                end
                            end else begin
                                state_nxt_s = ST_WAIT;
                            end
                        end
`ifdef JTFRAME_DUMP_LOADROM_EN
                        MODE_LOAD: begin
                            if (dl_fall) begin
                                state_nxt_s = ST_ACTIVE;
                            end else begin
                                state_nxt_s = ST_WAIT;
                            end
                        end
`endif
                        default: state_nxt_s = ST_IDLE;
                    endcase
                end
                ST_ACTIVE: begin
                    case (mode_r)
                        MODE_ONESHOT, MODE_LOAD: begin
                            if (tick && (stop_r != '0) && (nxt == stop_r)) begin
                                state_nxt_s = ST_DONE;
                            end else begin
                                state_nxt_s = ST_ACTIVE;
                            end
                        end
                        MODE_FREE: state_nxt_s = ST_ACTIVE;
                        default:   state_nxt_s = ST_IDLE;
                    endcase
                end
                ST_DONE: state_nxt_s = ST_DONE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    assign dump_en_nxt = (state_nxt_s == ST_ACTIVE);

    // State, latched configuration and registered output decodes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            mode_r  <= MODE_OFF;
            start_r <= '0;
            stop_r  <= '0;
            dump_en <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            mode_r  <= mode_nxt_s;
            start_r <= start_nxt_s;
            stop_r  <= stop_nxt_s;
            dump_en <= (state_nxt_s == ST_ACTIVE);
            done    <= (state_nxt_s == ST_DONE);
        end
    end

endmodule

// File: rtl/jtframe_dump_ctrl.sv
// Frame-windowed capture controller: vsync/download edge detection, the
// saturating frame counter and CH independent capture windows.
// Optional feature macro: JTFRAME_DUMP_LOADROM_EN (LOAD mode channels).
module jtframe_dump_ctrl
    import jtframe_dump_pkg::*;
#(
    parameter int CH = 4,
    parameter int FW = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vs,
    input  logic             downloading,
    input  logic             rearm,
    input  logic [2*CH-1:0]  mode,
    input  logic [FW*CH-1:0] start_frame,
    input  logic [FW*CH-1:0] stop_frame,
    output logic [FW-1:0]    frame_cnt,
    output logic [CH-1:0]    dump_en,
    output logic             dump_any,
    output logic [CH-1:0]    done
);

    logic              vs_l;
    logic              dl_l;
    logic              init_r;
    logic              vs_fall_s;
    logic              dl_fall_s;
    logic              sat_s;
    logic              tick_s;
    logic [FW_MAX-1:0] cnt_ext_s;
    logic [FW-1:0]     nxt_s;
    logic [CH-1:0]     en_nxt_s;

    assign vs_fall_s = vs_l & ~vs;
    assign dl_fall_s = dl_l & ~downloading;
    assign cnt_ext_s = FW_MAX'(frame_cnt);
    assign sat_s     = cnt_sat(cnt_ext_s, FW);
    assign nxt_s     = FW'(sat_inc(cnt_ext_s, FW));
    // A frame may match only if the counter really advances to nxt
    assign tick_s    = vs_fall_s & ~dl_fall_s & ~sat_s;

    // Edge history, frame counter, startup strobe and combined enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_l      <= 1'b0;
            dl_l      <= 1'b0;
            init_r    <= 1'b1;
            frame_cnt <= '0;
            dump_any  <= 1'b0;
        end else begin
            vs_l     <= vs;
            dl_l     <= downloading;
            init_r   <= 1'b0;
            dump_any <= |en_nxt_s;
            if (dl_fall_s) begin
                frame_cnt <= '0;
            end else if (vs_fall_s) begin
                frame_cnt <= nxt_s;
            end else begin
                frame_cnt <= frame_cnt;
            end
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        jtframe_dump_win #(
            .FW(FW)
        ) u_win (
            .clk         (clk),
            .rst_n       (rst_n),
            .init        (init_r),
            .rearm       (rearm),
            .tick        (tick_s),
            .nxt         (nxt_s),
`ifdef JTFRAME_DUMP_LOADROM_EN
            .dl_fall     (dl_fall_s),
`endif
            .mode        (mode[2*i +: 2]),
            .start       (start_frame[FW*i +: FW]),
            .stop        (stop_frame[FW*i +: FW]),
            .dump_en     (dump_en[i]),
            .dump_en_nxt (en_nxt_s[i]),
            .done        (done[i])
        );
    end

endmodule

// File: tb/tb_jtframe_dump_ctrl.sv
// Bench for jtframe_dump_ctrl: a wide instance (CH=4, FW=32) and a narrow
// one (CH=2, FW=4) share vs/downloading/rearm/rst_n and are checked every
// cycle against an event-level model, plus directed literal expectations.
// Honours JTFRAME_DUMP_LOADROM_EN for the LOAD-mode expectations.
module tb_jtframe_dump_ctrl;

`ifdef JTFRAME_DUMP_LOADROM_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    logic clk, rst_n, vs, downloading, rearm;
    logic [7:0]   a_mode;
    logic [127:0] a_start, a_stop;
    logic [31:0]  a_frame_cnt;
    logic [3:0]   a_dump_en, a_done;
    logic         a_dump_any;
    logic [3:0]   b_mode;
    logic [7:0]   b_start, b_stop;
    logic [3:0]   b_frame_cnt;
    logic [1:0]   b_dump_en, b_done;
    logic         b_dump_any;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    jtframe_dump_ctrl #(.CH(4), .FW(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading), .rearm(rearm),
        .mode(a_mode), .start_frame(a_start), .stop_frame(a_stop),
        .frame_cnt(a_frame_cnt), .dump_en(a_dump_en), .dump_any(a_dump_any), .done(a_done)
    );

    jtframe_dump_ctrl #(.CH(2), .FW(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading), .rearm(rearm),
        .mode(b_mode), .start_frame(b_start), .stop_frame(b_stop),
        .frame_cnt(b_frame_cnt), .dump_en(b_dump_en), .dump_any(b_dump_any), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Channels 0..3 belong to instance A, 4..5 to instance B.
    // Window phase: 0 unarmed, 1 armed waiting, 2 capturing, 3 closed.
    typedef struct {
        int          m;
        logic [63:0] s;
        logic [63:0] p;
        int          ph;
    } chm_t;

    chm_t        mdl [6];
    logic [63:0] fc [2];
    bit          mvs_l, mdl_l, minit;

    function automatic int cfg_mode(int c);
        if (c < 4) return int'(a_mode[2*c +: 2]);
        else       return int'(b_mode[2*(c-4) +: 2]);
    endfunction

    function automatic logic [63:0] cfg_start(int c);
        if (c < 4) return 64'(a_start[32*c +: 32]);
        else       return 64'(b_start[4*(c-4) +: 4]);
    endfunction

    function automatic logic [63:0] cfg_stop(int c);
        if (c < 4) return 64'(a_stop[32*c +: 32]);
        else       return 64'(b_stop[4*(c-4) +: 4]);
    endfunction

    // One clock of a window: arming first, then frame-number events
    function automatic chm_t win_step(chm_t w, int c, bit arm, bit adv, logic [63:0] newf, bit dlf);
        int em;
        em = cfg_mode(c);
        if (em == 2 && !LOAD_EN) em = 0;
        if (arm) begin
            w.m = em; w.s = cfg_start(c); w.p = cfg_stop(c);
            w.ph = (em == 0) ? 0 : 1;
            return w;
        end
        if (w.ph == 1) begin
            if (w.m == 2) begin
                if (dlf) w.ph = 2;
            end else if (w.s == 64'd0) begin
                w.ph = 2;
            end else if (adv && newf == w.s) begin
                w.ph = (w.m == 1 && w.p != 64'd0 && w.p <= w.s) ? 3 : 2;
            end
        end else if (w.ph == 2) begin
            if (w.m != 3 && adv && w.p != 64'd0 && newf == w.p) w.ph = 3;
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 6; c++) begin
            mdl[c].m = 0; mdl[c].s = 64'd0; mdl[c].p = 64'd0; mdl[c].ph = 0;
        end
        fc[0] = 64'd0; fc[1] = 64'd0;
        mvs_l = 1'b0; mdl_l = 1'b0; minit = 1'b1;
    endtask

    task automatic model_step();
        bit vf, dlf, adv;
        logic [63:0] top, newf;
        vf  = mvs_l && !vs;
        dlf = mdl_l && !downloading;
        for (int k = 0; k < 2; k++) begin
            top  = (k == 0) ? 64'hFFFF_FFFF : 64'hF;
            newf = (fc[k] == top) ? fc[k] : fc[k] + 64'd1;
            adv  = vf && !dlf && (fc[k] != top);
            for (int c = (k == 0 ? 0 : 4); c < (k == 0 ? 4 : 6); c++)
                mdl[c] = win_step(mdl[c], c, rearm || (minit && mdl[c].ph == 0), adv, newf, dlf);
            if (dlf)     fc[k] = 64'd0;
            else if (vf) fc[k] = newf;
        end
        mvs_l = vs; mdl_l = downloading; minit = 1'b0;
    endtask

    // Model advances on the same edges as the design
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [3:0] ea_en, ea_dn;
        logic [1:0] eb_en, eb_dn;
        for (int c = 0; c < 4; c++) begin
            ea_en[c] = (mdl[c].ph == 2); ea_dn[c] = (mdl[c].ph == 3);
        end
        for (int c = 0; c < 2; c++) begin
            eb_en[c] = (mdl[c+4].ph == 2); eb_dn[c] = (mdl[c+4].ph == 3);
        end
        chk("a_frame_cnt", 64'(a_frame_cnt), fc[0]);
        chk("a_dump_en",   64'(a_dump_en),   64'(ea_en));
        chk("a_done",      64'(a_done),      64'(ea_dn));
        chk("a_dump_any",  64'(a_dump_any),  64'(|ea_en));
        chk("b_frame_cnt", 64'(b_frame_cnt), fc[1]);
        chk("b_dump_en",   64'(b_dump_en),   64'(eb_en));
        chk("b_done",      64'(b_done),      64'(eb_dn));
        chk("b_dump_any",  64'(b_dump_any),  64'(|eb_en));
    endtask

    // Every clock passes through here: wait for the inactive edge, then compare
    task automatic cyc();
        @(negedge clk);
        if (chk_on) compare_model();
    endtask

    task automatic vs_pulse();
        vs = 1'b1; cyc(); cyc();
        vs = 1'b0; cyc(); cyc();
    endtask

    task automatic set_a(input int c, input logic [1:0] m, input logic [31:0] s, input logic [31:0] p);
        a_mode[2*c +: 2] = m; a_start[32*c +: 32] = s; a_stop[32*c +: 32] = p;
    endtask

    task automatic set_b(input int c, input logic [1:0] m, input logic [3:0] s, input logic [3:0] p);
        b_mode[2*c +: 2] = m; b_start[4*c +: 4] = s; b_stop[4*c +: 4] = p;
    endtask

    task automatic do_rearm();
        rearm = 1'b1; cyc();
        rearm = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; vs = 1'b0; downloading = 1'b0; rearm = 1'b0;
        a_mode = 8'd0; a_start = 128'd0; a_stop = 128'd0;
        b_mode = 4'd0; b_start = 8'd0; b_stop = 8'd0;
        set_a(0, 2'd1, 32'd5, 32'd8);
        set_a(1, 2'd1, 32'd6, 32'd4);
        set_a(2, 2'd3, 32'd0, 32'd0);
        set_a(3, 2'd2, 32'd0, 32'd3);
        set_b(0, 2'd3, 4'd15, 4'd0);
        set_b(1, 2'd1, 4'd0, 4'd0);

        repeat (3) cyc();
        chk("rst_a_frame", 64'(a_frame_cnt), 64'd0);
        chk("rst_a_en",    64'(a_dump_en),   64'd0);
        chk("rst_a_done",  64'(a_done),      64'd0);
        chk("rst_a_any",   64'(a_dump_any),  64'd0);
        chk_on = 1'b1;
        rst_n  = 1'b1;
        cyc();
        chk("start0_1clk", 64'(a_dump_en[2]), 64'd0);
        cyc();
        chk("start0_2clk", 64'(a_dump_en[2]), 64'd1);

        // ONESHOT windows and narrow-counter saturation
        for (int k = 1; k <= 20; k++) begin
            vs_pulse();
            chk("os_frame",    64'(a_frame_cnt),  64'(k));
            chk("os_en0",      64'(a_dump_en[0]), 64'(k >= 5 && k < 8));
            chk("os_done0",    64'(a_done[0]),    64'(k >= 8));
            chk("inv_en1",     64'(a_dump_en[1]), 64'd0);
            chk("inv_done1",   64'(a_done[1]),    64'(k >= 6));
            chk("b_sat_frame", 64'(b_frame_cnt),  (k > 15) ? 64'd15 : 64'(k));
            chk("b_free15",    64'(b_dump_en[0]), 64'(k >= 15));
        end

        // LOAD window relative to end of download
        downloading = 1'b1;
        repeat (4) vs_pulse();
        chk("dl_frame", 64'(a_frame_cnt), 64'd24);
        downloading = 1'b0;
        cyc();
        chk("dl_clear_a", 64'(a_frame_cnt),  64'd0);
        chk("dl_clear_b", 64'(b_frame_cnt),  64'd0);
        chk("load_open",  64'(a_dump_en[3]), 64'(LOAD_EN));
        vs_pulse(); vs_pulse();
        chk("load_mid",   64'(a_dump_en[3]), 64'(LOAD_EN));
        vs_pulse();
        chk("load_f3",    64'(a_frame_cnt),  64'd3);
        chk("load_close", 64'(a_dump_en[3]), 64'd0);
        chk("load_done",  64'(a_done[3]),    64'(LOAD_EN));

        // Simultaneous vsync and download falls
        vs = 1'b1; downloading = 1'b1; cyc(); cyc();
        vs = 1'b0; downloading = 1'b0; cyc();
        chk("simul_a", 64'(a_frame_cnt), 64'd0);
        chk("simul_b", 64'(b_frame_cnt), 64'd0);

        // rearm while a FREE window is open
        set_a(2, 2'd1, 32'd100, 32'd0);
        do_rearm();
        chk("rearm_en2",  64'(a_dump_en[2]), 64'd0);
        chk("rearm_done", 64'(a_done),       64'd0);
        cyc();
        chk("rearm_wait", 64'(a_dump_en[2]), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0)  vs = ~vs;
            if ($urandom_range(0, 59) == 0) downloading = ~downloading;
            if ($urandom_range(0, 24) == 0) begin
                int c;
                c = int'($urandom_range(0, 5));
                if (c < 4) set_a(c, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 12)), 32'($urandom_range(0, 12)));
                else       set_b(c - 4, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
            rearm = ($urandom_range(0, 49) == 0);
            cyc();
        end
        rearm = 1'b0;

        // Reset in the middle of an open window
        vs = 1'b0; downloading = 1'b1; cyc(); cyc(); cyc();
        downloading = 1'b0; cyc(); cyc();
        set_a(0, 2'd1, 32'd5, 32'd10);
        set_a(1, 2'd0, 32'd0, 32'd0);
        set_a(2, 2'd3, 32'd0, 32'd0);
        set_a(3, 2'd0, 32'd0, 32'd0);
        do_rearm();
        cyc();
        repeat (7) vs_pulse();
        chk("pre_rst_frame", 64'(a_frame_cnt),  64'd7);
        chk("pre_rst_en0",   64'(a_dump_en[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_a_frame", 64'(a_frame_cnt), 64'd0);
        chk("async_a_en",    64'(a_dump_en),   64'd0);
        chk("async_a_any",   64'(a_dump_any),  64'd0);
        chk("async_b_en",    64'(b_dump_en),   64'd0);
        chk("async_a_done",  64'(a_done),      64'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rel_1clk", 64'(a_dump_en[2]), 64'd0);
        cyc();
        chk("rel_2clk", 64'(a_dump_en[2]), 64'd1);
        repeat (4) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
